// File: rtl/rsa_ctrl_seq.sv
// rsa_ctrl_seq: start/stop arbitration and enable/reset sequencing for the RSA
// unit, with a programmable RUN watchdog and end-of-conversion reporting
// (sticky level plus one-cycle strobe). All outputs come straight from flops.
module rsa_ctrl_seq #(
   parameter int N_SRC      = 2,
   parameter int RST_CYCLES = 2,
   parameter int EOC_HOLD   = 2,
   parameter int TIMEOUT_W  = 16,
   localparam int SRC_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 ena,
   input  logic [N_SRC-1:0]     start_req,
   input  logic [N_SRC-1:0]     stop_req,
   input  logic [TIMEOUT_W-1:0] timeout_max,
   input  logic                 eoc_rsa_unit,
   output logic                 en_rsa,
   output logic                 rst_rsa,
   output logic                 eoc,
   output logic                 eoc_pulse,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [SRC_W-1:0]     src_id
);

   // One phase counter serves both RESET and HOLD; size it for the longer one.
   localparam int PH_MAX = (RST_CYCLES > EOC_HOLD) ? RST_CYCLES : EOC_HOLD;
   localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RESET = 3'd1,
      S_RUN   = 3'd2,
      S_DONE  = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [PH_W-1:0]      ph_cnt_q, ph_cnt_d;
   logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic                 eoc_q, eoc_d;
   logic                 err_q, err_d;
   logic [SRC_W-1:0]     src_id_q, src_id_d;
   logic                 en_q, en_d;
   logic                 rst_q, rst_d;
   logic                 busy_q, busy_d;
   logic                 pulse_q, pulse_d;

   logic                 any_start_s;
   logic                 any_stop_s;
   logic                 rst_last_s;
   logic                 hold_last_s;
   logic                 wd_expire_s;
   logic [TIMEOUT_W-1:0] wd_inc_s;

   // Fixed priority: the lowest-numbered requesting source wins.
   function automatic logic [SRC_W-1:0] lowest_set(input logic [N_SRC-1:0] req);
      logic [SRC_W-1:0] idx;
      idx = {SRC_W{1'b0}};
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx = SRC_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   assign any_start_s = |start_req;
   assign any_stop_s  = |stop_req;
   assign rst_last_s  = (ph_cnt_q == PH_W'(RST_CYCLES - 1));
   assign hold_last_s = (ph_cnt_q == PH_W'(EOC_HOLD - 1));
   // Expiry on the last allowed RUN cycle, so RUN never exceeds timeout_max cycles.
   assign wd_expire_s = (timeout_max != {TIMEOUT_W{1'b0}}) &&
                        (wd_cnt_q == (timeout_max - TIMEOUT_W'(1)));
   // Saturating increment: the watchdog count never wraps back to zero.
   assign wd_inc_s    = (wd_cnt_q == {TIMEOUT_W{1'b1}}) ? wd_cnt_q
                                                        : (wd_cnt_q + TIMEOUT_W'(1));

   // Next-state, counter and sticky-flag logic of the sequencer.
   always_comb begin
      state_d  = state_q;
      ph_cnt_d = ph_cnt_q;
      wd_cnt_d = wd_cnt_q;
      eoc_d    = eoc_q;
      err_d    = err_q;
      src_id_d = src_id_q;
      case (state_q)
         S_IDLE: begin
            if (any_start_s) begin
               state_d  = S_RESET;
               ph_cnt_d = {PH_W{1'b0}};
               eoc_d    = 1'b0;
               err_d    = 1'b0;
               src_id_d = lowest_set(start_req);
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_RESET: begin
            if (any_stop_s) begin
               state_d  = S_IDLE;
            end else if (rst_last_s) begin
               state_d  = S_RUN;
               wd_cnt_d = {TIMEOUT_W{1'b0}};
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         S_RUN: begin
            // Abort beats completion, completion beats the watchdog.
            if (any_stop_s) begin
               state_d  = S_IDLE;
            end else if (eoc_rsa_unit) begin
               state_d  = S_DONE;
               eoc_d    = 1'b1;
            end else if (wd_expire_s) begin
               state_d  = S_IDLE;
               err_d    = 1'b1;
            end else begin
               wd_cnt_d = wd_inc_s;
            end
         end
         S_DONE: begin
            // Stop is ignored from here on: the result is already valid.
            state_d  = S_HOLD;
            ph_cnt_d = {PH_W{1'b0}};
         end
         S_HOLD: begin
            if (hold_last_s) begin
               state_d  = S_IDLE;
            end else begin
               ph_cnt_d = ph_cnt_q + PH_W'(1);
            end
         end
         default: begin
            state_d  = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so the registered outputs track the state.
   always_comb begin
      en_d    = 1'b0;
      rst_d   = 1'b0;
      busy_d  = 1'b1;
      pulse_d = 1'b0;
      case (state_d)
         S_IDLE: begin
            busy_d  = 1'b0;
         end
         S_RESET: begin
            en_d    = 1'b1;
         end
         S_RUN: begin
            en_d    = 1'b1;
            rst_d   = 1'b1;
         end
         S_DONE: begin
            en_d    = 1'b1;
            rst_d   = 1'b1;
            pulse_d = 1'b1;
         end
         S_HOLD: begin
            rst_d   = 1'b1;
         end
         default: begin
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counters, flags and outputs; synchronous reset, frozen while ena is low.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q  <= S_IDLE;
         ph_cnt_q <= {PH_W{1'b0}};
         wd_cnt_q <= {TIMEOUT_W{1'b0}};
         eoc_q    <= 1'b0;
         err_q    <= 1'b0;
         src_id_q <= {SRC_W{1'b0}};
         en_q     <= 1'b0;
         rst_q    <= 1'b0;
         busy_q   <= 1'b0;
         pulse_q  <= 1'b0;
      end else if (ena) begin
         state_q  <= state_d;
         ph_cnt_q <= ph_cnt_d;
         wd_cnt_q <= wd_cnt_d;
         eoc_q    <= eoc_d;
         err_q    <= err_d;
         src_id_q <= src_id_d;
         en_q     <= en_d;
         rst_q    <= rst_d;
         busy_q   <= busy_d;
         pulse_q  <= pulse_d;
      end else begin
         state_q  <= state_q;
         ph_cnt_q <= ph_cnt_q;
         wd_cnt_q <= wd_cnt_q;
         eoc_q    <= eoc_q;
         err_q    <= err_q;
         src_id_q <= src_id_q;
         en_q     <= en_q;
         rst_q    <= rst_q;
         busy_q   <= busy_q;
         pulse_q  <= pulse_q;
      end
   end

   assign en_rsa      = en_q;
   assign rst_rsa     = rst_q;
   assign eoc         = eoc_q;
   assign eoc_pulse   = pulse_q;
   assign busy        = busy_q;
   assign timeout_err = err_q;
   assign src_id      = src_id_q;

endmodule

// File: tb/tb_rsa_ctrl_seq.sv
// Bench for rsa_ctrl_seq: directed scenarios plus randomized traffic. A job-level
// reference model (cycles since start, cycle of completion) predicts every output
// each cycle; a separate monitor pops those predictions and compares.
module tb_rsa_ctrl_seq;
   localparam int N_SRC      = 2;
   localparam int RST_CYCLES = 2;
   localparam int EOC_HOLD   = 2;
   localparam int TIMEOUT_W  = 16;
   localparam int SW         = 1;

   logic                 clk = 1'b0;
   logic                 rstb;
   logic                 ena;
   logic [N_SRC-1:0]     start_req;
   logic [N_SRC-1:0]     stop_req;
   logic [TIMEOUT_W-1:0] timeout_max;
   logic                 eoc_rsa_unit;
   logic                 en_rsa, rst_rsa, eoc, eoc_pulse, busy, timeout_err;
   logic [SW-1:0]        src_id;

   typedef struct packed {
      logic          en;
      logic          rst;
      logic          eoc;
      logic          pulse;
      logic          busy;
      logic          err;
      logic [SW-1:0] src;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   rsa_ctrl_seq #(
      .N_SRC(N_SRC), .RST_CYCLES(RST_CYCLES), .EOC_HOLD(EOC_HOLD), .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk), .rstb(rstb), .ena(ena), .start_req(start_req), .stop_req(stop_req),
      .timeout_max(timeout_max), .eoc_rsa_unit(eoc_rsa_unit), .en_rsa(en_rsa),
      .rst_rsa(rst_rsa), .eoc(eoc), .eoc_pulse(eoc_pulse), .busy(busy),
      .timeout_err(timeout_err), .src_id(src_id)
   );

   always #5 clk = ~clk;

   function automatic int lowest(input logic [N_SRC-1:0] v);
      for (int i = 0; i < N_SRC; i++) begin
         if (v[i]) return i;
      end
      return 0;
   endfunction

   // Reference model: a job is "active" from acceptance; age counts enabled cycles
   // since acceptance (1 = first busy cycle); done_age is the age of the DONE cycle.
   initial begin
      int   m_active, m_age, m_done_age, m_src;
      logic m_eoc, m_err;
      exp_t e;
      m_active = 0; m_age = 0; m_done_age = 0; m_src = 0; m_eoc = 1'b0; m_err = 1'b0;
      forever begin
         @(posedge clk);
         if (!rstb) begin
            m_active = 0; m_age = 0; m_done_age = 0; m_src = 0; m_eoc = 1'b0; m_err = 1'b0;
         end else if (ena) begin
            if (m_active == 0) begin
               if (start_req != '0) begin
                  m_active = 1; m_age = 1; m_done_age = 0;
                  m_eoc = 1'b0; m_err = 1'b0; m_src = lowest(start_req);
               end
            end else if (m_done_age == 0) begin
               if (m_age <= RST_CYCLES) begin
                  if (stop_req != '0) m_active = 0;
                  else m_age++;
               end else begin
                  if (stop_req != '0) m_active = 0;
                  else if (eoc_rsa_unit) begin
                     m_eoc = 1'b1; m_age++; m_done_age = m_age;
                  end else if (timeout_max != '0 && (m_age - RST_CYCLES) == int'(timeout_max)) begin
                     m_active = 0; m_err = 1'b1;
                  end else m_age++;
               end
            end else begin
               if (m_age == m_done_age + EOC_HOLD) m_active = 0;
               else m_age++;
            end
         end
         e.eoc  = m_eoc;
         e.err  = m_err;
         e.src  = SW'(m_src);
         e.busy = (m_active != 0);
         if (m_active == 0) begin
            e.en = 1'b0; e.rst = 1'b0; e.pulse = 1'b0;
         end else if (m_done_age == 0) begin
            e.en = 1'b1; e.rst = (m_age > RST_CYCLES); e.pulse = 1'b0;
         end else begin
            e.en = (m_age == m_done_age); e.rst = 1'b1; e.pulse = (m_age == m_done_age);
         end
         exp_q.push_back(e);
      end
   end

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end else begin
         n_pass++;
      end
   endtask

   // Monitor: outputs are presented every cycle; compare them on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("en_rsa",      8'(en_rsa),      8'(e.en));
            chk("rst_rsa",     8'(rst_rsa),     8'(e.rst));
            chk("eoc",         8'(eoc),         8'(e.eoc));
            chk("eoc_pulse",   8'(eoc_pulse),   8'(e.pulse));
            chk("busy",        8'(busy),        8'(e.busy));
            chk("timeout_err", 8'(timeout_err), 8'(e.err));
            chk("src_id",      8'(src_id),      8'(e.src));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Stimulus: test-plan scenarios, then randomized traffic.
   initial begin
      rstb = 1'b0; ena = 1'b1; start_req = '0; stop_req = '0;
      timeout_max = '0; eoc_rsa_unit = 1'b0;
      step(3);
      rstb = 1'b1;
      step(2);

      // Nominal: start from source 1 at cycle 0, completion sampled at cycle 10.
      start_req = 2'b10; step(1); start_req = 2'b00;
      step(9);
      eoc_rsa_unit = 1'b1; step(1); eoc_rsa_unit = 1'b0;
      step(8);

      // Arbitration and ignored start during RUN.
      start_req = 2'b11; step(1); start_req = 2'b00;
      step(4);
      start_req = 2'b01; step(2); start_req = 2'b00;
      step(2);
      eoc_rsa_unit = 1'b1; step(1); eoc_rsa_unit = 1'b0;
      step(6);

      // Abort on the third RUN cycle.
      start_req = 2'b01; step(1); start_req = 2'b00;
      step(4);
      stop_req = 2'b01; step(1); stop_req = 2'b00;
      step(3);

      // Watchdog expiry, then a new start clears the error.
      timeout_max = 16'd5;
      start_req = 2'b10; step(1); start_req = 2'b00;
      step(12);
      start_req = 2'b01; step(1); start_req = 2'b00;
      step(3);
      eoc_rsa_unit = 1'b1; step(1); eoc_rsa_unit = 1'b0;
      step(6);

      // Clock enable low mid-RUN while completion pulses; watchdog resumes.
      timeout_max = 16'd20;
      start_req = 2'b01; step(1); start_req = 2'b00;
      step(5);
      ena = 1'b0; step(1);
      eoc_rsa_unit = 1'b1; step(2); eoc_rsa_unit = 1'b0;
      step(1); ena = 1'b1;
      step(30);
      timeout_max = 16'd0;

      // Synchronous reset while in DONE.
      start_req = 2'b10; step(1); start_req = 2'b00;
      step(3);
      eoc_rsa_unit = 1'b1; step(1); eoc_rsa_unit = 1'b0;
      rstb = 1'b0; step(1); rstb = 1'b1;
      step(3);

      // Reset glitch between edges must be invisible.
      start_req = 2'b01; step(1); start_req = 2'b00;
      step(1);
      #1 rstb = 1'b0;
      #2 rstb = 1'b1;
      step(3);
      eoc_rsa_unit = 1'b1; step(1); eoc_rsa_unit = 1'b0;
      step(6);

      // Back-to-back jobs with start held high.
      start_req = 2'b10;
      for (int i = 0; i < 40; i++) begin
         eoc_rsa_unit = ((i % 7) == 6);
         step(1);
      end
      start_req = 2'b00; eoc_rsa_unit = 1'b0;
      step(8);

      // Randomized traffic.
      for (int i = 0; i < 1200; i++) begin
         if ((i % 60) == 0) timeout_max = 16'($urandom_range(0, 12));
         start_req    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
         stop_req     = ($urandom_range(0, 29) == 0) ? 2'($urandom) : 2'b00;
         eoc_rsa_unit = ($urandom_range(0, 9) == 0);
         ena          = ($urandom_range(0, 7) != 0);
         rstb         = ($urandom_range(0, 199) != 0);
         step(1);
      end
      rstb = 1'b1; ena = 1'b1; start_req = '0; stop_req = '0; eoc_rsa_unit = 1'b0;
      step(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/rsa_ctrl_seq.md
# rsa_ctrl_seq

Parametrised control sequencer for the RSA encryption unit. It arbitrates start/stop requests from N_SRC command sources (GPIO, SPI, …) and generates the enable and active-low reset for the RSA unit. It supervises completion with a programmable watchdog and reports end-of-conversion to the requesting interfaces as a sticky level and a one-cycle pulse. It sits between the GPIO/SPI command logic and the RSA unit, and replaces the fixed single-source enable logic.

## Interface
Parameters:
- N_SRC, 2: number of command sources (≥1).
- RST_CYCLES, 2: cycles rst_rsa is held low before the unit runs (≥1).
- EOC_HOLD, 2: cycles spent in HOLD after DONE (≥1).
- TIMEOUT_W, 16: width of the watchdog limit and counter.

Ports:
- clk, in, 1: single clock; everything is on its rising edge.
- rstb, in, 1: reset, synchronous, active-low.
- ena, in, 1: clock enable; when low, state, counters and outputs hold.
- start_req, in, N_SRC: per-source start request, level-sampled.
- stop_req, in, N_SRC: per-source abort request; any bit high aborts.
- timeout_max, in, TIMEOUT_W: watchdog limit in RUN cycles; 0 disables the watchdog.
- eoc_rsa_unit, in, 1: completion flag from the RSA unit.
- en_rsa, out, 1: enable to the RSA unit.
- rst_rsa, out, 1: active-low reset to the RSA unit.
- eoc, out, 1: sticky end-of-conversion.
- eoc_pulse, out, 1: one-cycle end-of-conversion strobe.
- busy, out, 1: high whenever the sequencer is not in IDLE.
- timeout_err, out, 1: sticky watchdog error.
- src_id, out, max(1,$clog2(N_SRC)): index of the source that won the last accepted start.

## Operation
- All outputs are registered.
- Reset values (rstb=0 at a clock edge): state=IDLE, en_rsa=0, rst_rsa=0, eoc=0, eoc_pulse=0, busy=0, timeout_err=0, src_id=0, all counters 0.
- The reset pulls the sequencer to IDLE from any state, including mid-conversion.
- States and output decode:
  - IDLE: en=0, rst=0, busy=0.
  - RESET: en=1, rst=0.
  - RUN: en=1, rst=1.
  - DONE: en=1, rst=1, eoc_pulse=1.
  - HOLD: en=0, rst=1.
- IDLE→RESET when any start_req bit is high.
  - Arbitration: the lowest set index wins and is latched into src_id.
  - eoc and timeout_err are cleared on this transition.
- Start requests are ignored in every state except IDLE. No queuing.
- RESET→RUN after RST_CYCLES cycles in RESET.
- RUN priority, highest first, evaluated each enabled cycle:
  1. Any stop_req high → IDLE (abort). eoc stays 0, timeout_err unchanged.
  2. eoc_rsa_unit=1 → DONE.
  3. Watchdog expiry → IDLE, timeout_err=1.
- Any stop_req in RESET → IDLE immediately. Stop in DONE or HOLD is ignored; the result is already valid.
- Watchdog:
  - Counter cleared on RUN entry; counts enabled RUN cycles from 0.
  - Expiry when timeout_max≠0 and count==timeout_max−1 with eoc_rsa_unit low, so RUN lasts at most timeout_max cycles.
  - The counter saturates and never wraps.
- DONE→HOLD after 1 cycle; eoc is set on DONE entry.
- HOLD→IDLE after EOC_HOLD cycles.
- eoc remains high in IDLE until the next accepted start.
- With ena=0, no transition occurs, counters do not advance, and inputs are not sampled.

## Timing
- Start sampled at edge t (IDLE, ena=1): from t+1, busy=1, en_rsa=1, rst_rsa=0.
- rst_rsa rises at t+1+RST_CYCLES, the first RUN cycle.
- eoc_rsa_unit sampled high at edge u in RUN: eoc=1 and eoc_pulse=1 at u+1; eoc_pulse=0 and en_rsa=0 at u+2.
- busy falls at u+2+EOC_HOLD.
- Minimum start-to-IDLE: 1 + RST_CYCLES + 1 (RUN) + 1 + EOC_HOLD cycles.
- Back-to-back: a start held high across IDLE is accepted on the first IDLE cycle, i.e. one idle cycle between jobs.
- Simultaneous stop and eoc_rsa_unit in RUN: stop wins, eoc stays 0.
- Simultaneous eoc_rsa_unit and watchdog expiry: eoc wins, no error.

## Test plan
- Nominal, N_SRC=2, RST_CYCLES=2, EOC_HOLD=2, timeout_max=0:
  - Stimulus: pulse start_req=2'b10 at cycle 0; drive eoc_rsa_unit high at cycle 10.
  - Required: src_id=1; rst_rsa low cycles 1–2, high from 3; eoc and eoc_pulse at 11; busy low at 14; eoc stays 1 until the next start.
- Arbitration and ignore:
  - Stimulus: start_req=2'b11, then start_req=2'b01 again during RUN.
  - Required: src_id=0; the second request has no effect and busy never drops.
- Abort:
  - Stimulus: stop_req=2'b01 on the 3rd RUN cycle.
  - Required: next cycle is IDLE with en_rsa=0, rst_rsa=0, eoc=0, timeout_err=0.
- Watchdog:
  - Stimulus: timeout_max=5, eoc_rsa_unit never asserted.
  - Required: exactly 5 RUN cycles, then IDLE with timeout_err=1; a following start clears timeout_err.
- Clock enable:
  - Stimulus: ena=0 for 4 cycles mid-RUN while eoc_rsa_unit pulses high.
  - Required: all outputs frozen and the pulse is missed; the watchdog count resumes unchanged afterwards.
- Synchronous reset:
  - Stimulus: rstb=0 for one edge during DONE.
  - Required: all outputs at reset values on the next cycle; an asynchronous rstb glitch between edges has no effect.
